// File: rtl/text_pkg.sv
// Shared constants and types for the text buffer writer: ASCII control codes,
// default screen geometry and the writer FSM state encoding.
package text_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [6:0] ASC_BS    = 7'h08;
  localparam logic [6:0] ASC_LF    = 7'h0A;
  localparam logic [6:0] ASC_FF    = 7'h0C;
  localparam logic [6:0] ASC_CR    = 7'h0D;
  localparam logic [6:0] ASC_SPACE = 7'h20;
  localparam logic [6:0] ASC_DEL   = 7'h7F;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile RAM: one write port, one registered read port, read-first.
// No reset on the array or read register so it maps onto block RAM.
module tile_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 7
)(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer_writer.sv
// Character-stream writer for the on-screen text buffer: interprets control codes,
// tracks the cursor and fills the tile RAM read by the pixel-side renderer.
module text_buffer_writer
  import text_pkg::*;
#(
  parameter int  COLS   = DEF_COLS,
  parameter int  ROWS   = DEF_ROWS,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int ADDR_W = $clog2(COLS*ROWS)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             clear_req,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [6:0]       rd_char,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row,
  output logic             busy
);

  localparam int                CELLS    = COLS * ROWS;
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CELL_MAX = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LINE_MAX = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] cnt, row_base, col_a;
  logic [6:0]        code;
  logic              unused_msb;
  logic              accept, is_print, is_bs, do_nl, clr_all, cnt_last;
  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [6:0]        wdata, ram_q;
  logic              rd_in, rd_ok_q;

  // Bit 7 of the input byte carries no meaning for the 7-bit glyph set.
  assign code       = char_in[6:0];
  assign unused_msb = char_in[7];

  assign char_ready = (state == IDLE) && !clear_req;
  assign busy       = (state != IDLE);
  assign accept     = char_valid && char_ready;
  assign is_print   = (code >= ASC_SPACE) && (code < ASC_DEL);
  assign is_bs      = (code == ASC_BS) && (cur_col != '0);
  assign do_nl      = accept && ((is_print && cur_col == COL_MAX) || code == ASC_LF);
  assign clr_all    = clear_req || (accept && code == ASC_FF);
  assign cnt_last   = (state == CLEAR) ? (cnt == CELL_MAX) : (cnt == LINE_MAX);
  assign row_base   = ADDR_W'(cur_row) * COLS_A;
  assign col_a      = ADDR_W'(cur_col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr_all) begin
      state_nx = CLEAR;
    end else begin
      case (state)
        CLEAR:    if (cnt_last) state_nx = IDLE;
        CLR_LINE: if (cnt_last) state_nx = IDLE;
        default:  if (do_nl)    state_nx = CLR_LINE;
      endcase
    end
  end

  // Clear/line-clear cell counter; idles at zero so each pass starts at cell 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cnt <= '0;
    else if (clr_all || state == IDLE || cnt_last) cnt <= '0;
    else                                        cnt <= cnt + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (clr_all) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (accept) begin
      if (do_nl) begin
        cur_col <= '0;
        cur_row <= (cur_row == ROW_MAX) ? '0 : cur_row + ROW_W'(1);
      end else if (is_print) begin
        cur_col <= cur_col + COL_W'(1);
      end else if (code == ASC_CR) begin
        cur_col <= '0;
      end else if (is_bs) begin
        cur_col <= cur_col - COL_W'(1);
      end
    end
  end

  // Write port: clearing states own the RAM; in IDLE only accepted glyphs/BS write.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = row_base + cnt;
      end
      default: begin
        if (accept && is_print) begin
          we    = 1'b1;
          waddr = row_base + col_a;
          wdata = code;
        end else if (accept && is_bs) begin
          we    = 1'b1;
          waddr = row_base + col_a - ADDR_W'(1);
        end
      end
    endcase
  end

  // Out-of-range reads are masked after the RAM so the array itself stays reset-free.
  assign rd_in = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
  assign raddr = rd_in ? ADDR_W'(rd_row) * COLS_A + ADDR_W'(rd_col) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_ok_q <= 1'b0;
    else       rd_ok_q <= rd_in;
  end

  assign rd_char = rd_ok_q ? ram_q : 7'h00;

  tile_ram #(
    .DEPTH (CELLS),
    .AW    (ADDR_W),
    .DW    (7)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: read expectations go through a
// scoreboard queue and are compared when the registered read data appears.
module tb_text_buffer_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       clear_req = 1'b0;
  logic [6:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [6:0] rd_char;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int         total = 0;
  int         bad = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  text_buffer_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    char_in    = c;
    char_valid = 1'b1;
    #0;
    while (!char_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!char_ready) chk("send_timeout", 0, 1);
    tick();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input int col, input int row, input logic [6:0] exp);
    rd_col = 7'(col);
    rd_row = 5'(row);
    exp_q.push_back(exp);
    tick();
    chk($sformatf("rd(%0d,%0d)", col, row), rd_char, exp_q.pop_front());
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, cur_col, c);
    chk({tag, "_row"}, cur_row, r);
  endtask

  task automatic chk_row(input int row, input logic [6:0] exp);
    for (int c = 0; c < COLS; c++) rd(c, row, exp);
  endtask

  initial begin
    int n;
    int leaked;

    // Reset with a character already offered: nothing may be accepted during the clear.
    char_in    = 8'h58;
    char_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rd_char", rd_char, 0);
    chk_cur("rst", 0, 0);
    reset = 1'b0;
    n = 0;
    leaked = 0;
    while (busy && n < 5000) begin
      if (char_ready) leaked++;
      tick();
      n++;
    end
    chk("post_rst_ready", char_ready, 1);
    char_valid = 1'b0;
    chk("clear_cycles", n, 2400);
    chk("ready_during_clear", leaked, 0);
    chk_cur("after_clear", 0, 0);
    rd(0, 0, 7'h00);
    rd(79, 29, 7'h00);
    rd(40, 15, 7'h00);

    // Two printable characters back-to-back.
    send(8'h48);
    send(8'h49);
    chk_cur("hi", 2, 0);
    rd(0, 0, 7'h48);
    rd(1, 0, 7'h49);
    rd(2, 0, 7'h00);

    // Pre-fill row 1 with 'Z', then walk the cursor back to (0,0).
    send(8'h0D);
    send(8'h0A);
    for (int i = 0; i < COLS; i++) send(8'h5A);
    chk_cur("z_fill", 0, 2);
    for (int i = 0; i < 28; i++) send(8'h0A);
    wait_idle(n);
    chk_cur("wrap_home", 0, 0);
    rd(5, 1, 7'h5A);

    // Full row of 'A' wraps to row 1 and clears it.
    for (int i = 0; i < COLS; i++) send(8'h41);
    chk_cur("row_fill", 0, 1);
    n = 0;
    while (!char_ready && n < 5000) begin
      tick();
      n++;
    end
    chk("line_clr_cycles", n, 80);
    chk_row(0, 7'h41);
    chk_row(1, 7'h00);

    // LF on the last row wraps to row 0, clears it, leaves other rows alone.
    for (int i = 0; i < 27; i++) send(8'h0A);
    send(8'h51);
    send(8'h52);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    chk_cur("pre_wrap", 5, 29);
    send(8'h0A);
    chk_cur("lf_wrap", 0, 0);
    chk("lf_wrap_busy", busy, 1);
    wait_idle(n);
    chk_row(0, 7'h00);
    rd(0, 28, 7'h51);
    rd(1, 28, 7'h52);
    rd(2, 28, 7'h00);
    rd(0, 29, 7'h61);
    rd(80, 28, 7'h00);
    rd(0, 30, 7'h00);

    // Backspace, backspace at column 0, and an ignored control code.
    send(8'h0A);
    send(8'h0A);
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    chk_cur("xyz", 3, 2);
    send(8'h08);
    chk_cur("bs", 2, 2);
    rd(2, 2, 7'h00);
    rd(1, 2, 7'h79);
    send(8'h0D);
    send(8'h08);
    chk_cur("bs_col0", 0, 2);
    rd(0, 2, 7'h78);
    send(8'h07);
    chk_cur("bel", 0, 2);
    chk("bel_busy", busy, 0);

    // clear_req in the middle of a line clear, with a character offered.
    send(8'h0A);
    repeat (10) tick();
    clear_req  = 1'b1;
    char_in    = 8'h4B;
    char_valid = 1'b1;
    #1;
    chk("clr_mid_ready", char_ready, 0);
    tick();
    clear_req  = 1'b0;
    char_valid = 1'b0;
    chk_cur("clr_mid", 0, 0);
    wait_idle(n);
    chk("clr_mid_cycles", n, 2400);
    for (int r = 0; r < ROWS; r++) chk_row(r, 7'h00);

    // clear_req from IDLE blocks a same-cycle character; FF acts as a clear.
    send(8'h4D);
    chk_cur("m", 1, 0);
    clear_req  = 1'b1;
    char_in    = 8'h4B;
    char_valid = 1'b1;
    #1;
    chk("clr_idle_ready", char_ready, 0);
    tick();
    clear_req  = 1'b0;
    char_valid = 1'b0;
    chk_cur("clr_idle", 0, 0);
    chk("clr_idle_busy", busy, 1);
    wait_idle(n);
    rd(0, 0, 7'h00);
    rd(1, 0, 7'h00);
    send(8'h4D);
    send(8'h0C);
    chk_cur("ff", 0, 0);
    chk("ff_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Writer side of the on-screen text path: accepts an ASCII character stream over a valid/ready handshake.
- Interprets a small set of control codes, maintains a cursor, and stores character codes into an internal COLS x ROWS tile RAM.
- Exposes a registered read port that the pixel-side text renderer indexes by tile column/row; the renderer feeds the returned code to the ASCII font ROM.
- Sits between a character source (UART receiver, game logic) and the renderer.

Parameters:
- COLS, 80, tiles per row (640 px / 8 px glyph width)
- ROWS, 30, tile rows (480 px / 16 px glyph height)
- Localparams: COL_W=clog2(COLS)=7, ROW_W=clog2(ROWS)=5, ADDR_W=clog2(COLS*ROWS)=12

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- char_in  in  8  ASCII character to write
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept a character this cycle
- clear_req  in  1  one-cycle pulse: clear screen, cursor home
- rd_col  in  COL_W  renderer tile column
- rd_row  in  ROW_W  renderer tile row
- rd_char  out  7  character code at (rd_col, rd_row), 1-cycle latency
- cur_col  out  COL_W  cursor column
- cur_row  out  ROW_W  cursor row
- busy  out  1  a clear operation (full or line) is in progress

Behaviour:
- States:
  - CLEAR: write 0x00 to every cell, 1 cell/cycle, address 0 to COLS*ROWS-1.
  - IDLE
  - CLR_LINE: write 0x00 to the COLS cells of cur_row, 1 cell/cycle.
- Reset (async): state=CLEAR, clear counter=0, cur_col=0, cur_row=0, rd_char=0, char_ready=0, busy=1. The RAM is not reset; the post-reset CLEAR pass initialises it.
- CLEAR -> IDLE after the last cell (COLS*ROWS cycles). CLR_LINE -> IDLE after COLS cycles.
- char_ready = (state==IDLE) && !clear_req. busy = (state!=IDLE).
- Accept: char_valid && char_ready. One character per cycle, no bubbles. The RAM write happens on the accepting edge; cursor outputs update on the same edge.
- Character handling (char_in[7] ignored; 7-bit code used):
  - Printable 0x20-0x7E: write the code at (cur_col, cur_row); cur_col+1. If cur_col==COLS-1: new-line action.
  - 0x0D CR: cur_col=0.
  - 0x0A LF: new-line action.
  - 0x08 BS: if cur_col>0, cur_col-1 and write 0x00 at the new position; at col 0, no-op.
  - 0x0C FF: same as clear_req.
  - Any other code: consumed, no effect.
- New-line action:
  - cur_col=0.
  - cur_row+1; if cur_row==ROWS-1, wrap to 0.
  - Enter CLR_LINE on the new row. Existing rows are never moved; there is no scroll.
- clear_req: takes effect in any state, including mid-CLR_LINE or mid-CLEAR (restarts from address 0). Sets cursor to (0,0), state=CLEAR. If clear_req and char_valid occur in the same cycle, the character is not accepted.
- Read port:
  - Address = rd_row*COLS + rd_col; registered output, 1-cycle latency.
  - rd_col>=COLS or rd_row>=ROWS returns 0x00.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- Width rules: address arithmetic in ADDR_W bits. Counters compare against COLS-1/ROWS-1 explicitly and never rely on power-of-two overflow.

Decomposition:
- Package text_pkg holds:
  - ASCII constants: ASC_BS=0x08, ASC_LF=0x0A, ASC_FF=0x0C, ASC_CR=0x0D, ASC_SPACE=0x20, ASC_DEL=0x7F.
  - Default COLS/ROWS.
  - State enum {CLEAR, IDLE, CLR_LINE}.
- Sub-module tile_ram: simple dual-port RAM with 1 write port and 1 registered read port, depth COLS*ROWS, width 7, read-first. Must infer BRAM.

Test Plan:
- Reset release with char_valid=1: char_ready=0 and busy=1 for exactly 2400 cycles, then char_ready=1. Reading (0,0), (79,29) and (40,15) returns 0x00.
- Send 'H','I' (0x48, 0x49) back-to-back -> cells (0,0)=0x48 and (1,0)=0x49; cur_col=2, cur_row=0; rd_char is valid 1 cycle after the address is presented.
- Send 80 x 'A' from (0,0) -> row 0 is all 0x41; cur=(0,1); char_ready is low for exactly 80 cycles; row 1 pre-filled with 0x5A reads 0x00 afterwards.
- Cursor at (5,29), rows 0 and 28 hold data, send LF -> cur=(0,0); row 0 is cleared; row 28 is unchanged.
- Cursor at (3,2), send BS -> cur_col=2 and cell (2,2)=0x00. Send BS at (0,2) -> no change. Send 0x07 -> consumed, no change.
- clear_req mid-CLR_LINE with char_valid=1 in the same cycle -> character not accepted; cur=(0,0); busy is high for 2400 cycles; all cells read 0x00 afterwards.
